// File: rtl/seq_alu.sv
// Registered ALU with valid/ready handshake and an iterative shift-add multiplier.
// Define SEQ_ALU_DIV_EN to add iterative unsigned divu/remu (restoring, one bit per cycle).
module seq_alu #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] ina,
  input  logic [WIDTH-1:0] inb,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic             illegal,
  output logic             busy
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLTU = 4'b0111;
  localparam logic [3:0] OP_SLT  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_MUL  = 4'b1010;
`ifdef SEQ_ALU_DIV_EN
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REMU = 4'b1101;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc, mcand, mplier;
  logic [WIDTH-1:0]   sc_res, mul_acc, iter_res;
  logic [SHAMT_W-1:0] shamt;
  logic               sc_ill, is_iter, last;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state == BUSY);
  assign shamt     = inb[SHAMT_W-1:0];
  assign last      = (cnt == CNT_W'(1));
  assign mul_acc   = acc + (mplier[0] ? mcand : '0);

`ifdef SEQ_ALU_DIV_EN
  // Divide reuses the multiply registers: acc = partial remainder,
  // mplier = dividend shifting out / quotient shifting in, mcand = divisor.
  // A zero divisor falls out naturally as all-ones quotient, remainder = ina.
  logic             div_mode, rem_mode, div_ge;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_nxt, quo_nxt;

  assign rem_sh   = {acc, mplier[WIDTH-1]};
  assign div_ge   = (rem_sh >= {1'b0, mcand});
  assign rem_nxt  = WIDTH'(div_ge ? rem_sh - {1'b0, mcand} : rem_sh);
  assign quo_nxt  = {mplier[WIDTH-2:0], div_ge};
  assign is_iter  = (alu_op == OP_MUL) || (alu_op == OP_DIVU) || (alu_op == OP_REMU);
  assign iter_res = div_mode ? (rem_mode ? rem_nxt : quo_nxt) : mul_acc;
`else
  assign is_iter  = (alu_op == OP_MUL);
  assign iter_res = mul_acc;
`endif

  always_comb begin
    sc_res = '0;
    sc_ill = 1'b0;
    case (alu_op)
      OP_ADD:  sc_res = ina + inb;
      OP_SUB:  sc_res = ina - inb;
      OP_AND:  sc_res = ina & inb;
      OP_OR:   sc_res = ina | inb;
      OP_XOR:  sc_res = ina ^ inb;
      OP_SLL:  sc_res = ina << shamt;
      OP_SRL:  sc_res = ina >> shamt;
      OP_SRA:  sc_res = $signed(ina) >>> shamt;
      OP_SLTU: sc_res = {{(WIDTH-1){1'b0}}, (ina < inb)};
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(ina) < $signed(inb))};
      OP_MUL:  sc_res = '0;
      default: sc_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    if (in_valid) state_nxt = is_iter ? BUSY : DONE;
        BUSY:    if (last) state_nxt = DONE;
        DONE:    if (out_ready) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out      <= '0;
      zero     <= 1'b0;
      illegal  <= 1'b0;
      cnt      <= '0;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
`ifdef SEQ_ALU_DIV_EN
      div_mode <= 1'b0;
      rem_mode <= 1'b0;
`endif
    end else if (flush) begin
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          if (is_iter) begin
            acc    <= '0;
            cnt    <= CNT_W'(WIDTH);
            mcand  <= ina;
            mplier <= inb;
`ifdef SEQ_ALU_DIV_EN
            div_mode <= (alu_op != OP_MUL);
            rem_mode <= (alu_op == OP_REMU);
            if (alu_op != OP_MUL) begin
              mcand  <= inb;
              mplier <= ina;
            end
`endif
          end else begin
            out     <= sc_res;
            zero    <= (sc_res == '0);
            illegal <= sc_ill;
          end
        end
        BUSY: begin
          cnt <= cnt - CNT_W'(1);
`ifdef SEQ_ALU_DIV_EN
          if (div_mode) begin
            acc    <= rem_nxt;
            mplier <= quo_nxt;
          end else
`endif
          begin
            acc    <= mul_acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
          end
          if (last) begin
            out     <= iter_res;
            zero    <= (iter_res == '0);
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Directed self-checking bench for seq_alu at WIDTH=32; div checks follow SEQ_ALU_DIV_EN.
module tb_seq_alu;
  localparam int W = 32;

  logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0;
  logic         in_valid = 1'b0, out_ready = 1'b0;
  logic [3:0]   alu_op = 4'h0;
  logic [W-1:0] ina = '0, inb = '0;
  logic         in_ready, out_valid, zero, illegal, busy;
  logic [W-1:0] out;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .alu_op(alu_op), .ina(ina), .inb(inb), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .zero(zero), .illegal(illegal), .busy(busy)
  );

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    alu_op = op; ina = a; inb = b; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    tests++;
    if ({out, zero, illegal, out_valid, busy} !== '0) begin
      fails++;
      $display("FAIL reset_vals: out=%h z=%b ill=%b ov=%b busy=%b, want all 0", out, zero, illegal, out_valid, busy);
    end
    #1 rst_n = 1'b1;
    tick();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_single();
    logic [3:0]   ops[13] = '{4'b0010, 4'b1000, 4'b0111, 4'b1001, 4'b0110, 4'b0000, 4'b0001,
                              4'b0011, 4'b0100, 4'b0101, 4'b1000, 4'b0111, 4'b1001};
    logic [W-1:0] av[13]  = '{32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h80000000, 32'h5,
                              32'hF0F01234, 32'hF0000000, 32'hAAAA5555, 32'h1, 32'h80000000,
                              32'h3, 32'h3, 32'h7FFFFFFF};
    logic [W-1:0] bv[13]  = '{32'h1, 32'h3, 32'h3, 32'h24, 32'h7, 32'h0FF0FFFF, 32'h0000000F,
                              32'hFFFF0000, 32'h21, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h4};
    logic [W-1:0] ev[13]  = '{32'h0, 32'h1, 32'h0, 32'hF8000000, 32'hFFFFFFFE, 32'h00F01234,
                              32'hF000000F, 32'h55555555, 32'h2, 32'h1, 32'h0, 32'h1, 32'h07FFFFFF};
    for (int i = 0; i < 13; i++) begin
      issue(ops[i], av[i], bv[i]);
      tests++;
      if ({out_valid, out, zero, illegal, busy} !== {1'b1, ev[i], (ev[i] == '0), 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL single[%0d] op=%b: ov=%b out=%h z=%b ill=%b busy=%b, want ov=1 out=%h z=%b ill=0 busy=0",
                 i, ops[i], out_valid, out, zero, illegal, busy, ev[i], (ev[i] == '0));
      end
      release_out();
      tests++;
      if ({in_ready, out_valid} !== 2'b10) begin
        fails++;
        $display("FAIL single_release[%0d]: in_ready=%b ov=%b, want 1 0", i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_mul();
    logic [W-1:0] av[3] = '{32'h00012345, 32'hFFFFFFFF, 32'h00010000};
    logic [W-1:0] bv[3] = '{32'h00010000, 32'hFFFFFFFF, 32'h00010000};
    logic [W-1:0] ev[3] = '{32'h23450000, 32'h00000001, 32'h00000000};
    logic [W-1:0] held;
    int cyc, nb, bad, unstable;
    for (int i = 0; i < 3; i++) begin
      issue(4'b1010, av[i], bv[i]);
      cyc = 0; nb = 0; bad = 0;
      while (!out_valid && cyc < 200) begin
        if (busy) nb++;
        if (in_ready) bad++;
        tick();
        cyc++;
      end
      tests++;
      if (cyc + 1 != 33 || nb != 32 || bad != 0) begin
        fails++;
        $display("FAIL mul_timing[%0d]: latency=%0d busy_cycles=%0d in_ready_hi=%0d, want 33 32 0", i, cyc + 1, nb, bad);
      end
      tests++;
      if ({out, zero, illegal, busy} !== {ev[i], (ev[i] == '0), 1'b0, 1'b0}) begin
        fails++;
        $display("FAIL mul_result[%0d]: out=%h z=%b ill=%b busy=%b, want %h z=%b ill=0 busy=0",
                 i, out, zero, illegal, busy, ev[i], (ev[i] == '0));
      end
      if (i == 0) begin
        held = out;
        unstable = 0;
        for (int k = 0; k < 5; k++) begin
          tick();
          if (out_valid !== 1'b1 || out !== ev[0] || zero !== 1'b0) unstable++;
        end
        tests++;
        if (unstable != 0) begin
          fails++;
          $display("FAIL mul_stall_hold: %0d unstable cycles (out=%h ov=%b), want 0 with out=%h", unstable, out, out_valid, held);
        end
      end
      release_out();
      tests++;
      if (in_ready !== 1'b1) begin
        fails++;
        $display("FAIL mul_release[%0d]: in_ready=%b want 1", i, in_ready);
      end
    end
  endtask

  task automatic test_flush();
    int seen;
    issue(4'b1010, 32'h00012345, 32'h00010000);
    repeat (9) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tests++;
    if ({out_valid, in_ready, busy} !== 3'b010) begin
      fails++;
      $display("FAIL flush_busy: ov=%b in_ready=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
    end
    seen = 0;
    for (int k = 0; k < 40; k++) begin
      if (out_valid) seen++;
      tick();
    end
    tests++;
    if (seen != 0) begin
      fails++;
      $display("FAIL flush_no_result: out_valid seen %0d cycles, want 0", seen);
    end
    issue(4'b0010, 32'h1, 32'h1);
    flush = 1'b1;
    out_ready = 1'b0;
    tick();
    flush = 1'b0;
    tests++;
    if ({out_valid, in_ready} !== 2'b01) begin
      fails++;
      $display("FAIL flush_done: ov=%b in_ready=%b, want 0 1", out_valid, in_ready);
    end
  endtask

  task automatic test_rst_mid();
    issue(4'b0010, 32'h1, 32'h2);
    release_out();
    issue(4'b1010, 32'h3, 32'h4);
    repeat (4) tick();
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({out, zero, illegal, out_valid, busy} !== '0) begin
      fails++;
      $display("FAIL rst_mid_vals: out=%h z=%b ill=%b ov=%b busy=%b, want all 0", out, zero, illegal, out_valid, busy);
    end
    rst_n = 1'b1;
    tick();
    tests++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      fails++;
      $display("FAIL rst_mid_idle: in_ready=%b ov=%b busy=%b, want 1 0 0", in_ready, out_valid, busy);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] ops[3] = '{4'b1111, 4'b1110, 4'b1011};
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 32'h12345678, 32'h9);
      tests++;
      if ({out_valid, out, zero, illegal} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
        fails++;
        $display("FAIL illegal[%0d] op=%b: ov=%b out=%h z=%b ill=%b, want 1 0 1 1", i, ops[i], out_valid, out, zero, illegal);
      end
      release_out();
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    issue(4'b1010, 32'h3, 32'h4);
    alu_op = 4'b0010; ina = 32'h5; inb = 32'h6; in_valid = 1'b1;
    wait_done(cyc);
    tests++;
    if ({out_valid, out} !== {1'b1, 32'd12} || cyc != 32) begin
      fails++;
      $display("FAIL busy_ignore: ov=%b out=%h cyc=%0d, want 1 0000000c 32", out_valid, out, cyc);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    tests++;
    if ({in_ready, out_valid} !== 2'b10) begin
      fails++;
      $display("FAIL b2b_idle: in_ready=%b ov=%b, want 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    tests++;
    if ({out_valid, out, illegal} !== {1'b1, 32'd11, 1'b0}) begin
      fails++;
      $display("FAIL b2b_accept: ov=%b out=%h ill=%b, want 1 0000000b 0", out_valid, out, illegal);
    end
    release_out();
  endtask

  task automatic test_div();
    logic [3:0]   ops[4] = '{4'b1100, 4'b1101, 4'b1100, 4'b1101};
    logic [W-1:0] av[4]  = '{32'd100, 32'd100, 32'h00001234, 32'd9};
    logic [W-1:0] bv[4]  = '{32'd7, 32'd7, 32'd0, 32'd0};
`ifdef SEQ_ALU_DIV_EN
    logic [W-1:0] ev[4]  = '{32'd14, 32'd2, 32'hFFFFFFFF, 32'd9};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], av[i], bv[i]);
      wait_done(cyc);
      tests++;
      if ({out_valid, out, zero, illegal} !== {1'b1, ev[i], 1'b0, 1'b0} || cyc + 1 != 33) begin
        fails++;
        $display("FAIL div[%0d] op=%b: ov=%b out=%h z=%b ill=%b latency=%0d, want 1 %h 0 0 33",
                 i, ops[i], out_valid, out, zero, illegal, cyc + 1, ev[i]);
      end
      release_out();
    end
`else
    for (int i = 0; i < 2; i++) begin
      issue(ops[i + 2], av[i], bv[i]);
      tests++;
      if ({out_valid, out, zero, illegal} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
        fails++;
        $display("FAIL div_disabled[%0d] op=%b: ov=%b out=%h z=%b ill=%b, want 1 0 1 1",
                 i, ops[i + 2], out_valid, out, zero, illegal);
      end
      release_out();
    end
`endif
  endtask

  initial begin
    test_reset();
    test_single();
    test_mul();
    test_flush();
    test_rst_mid();
    test_illegal();
    test_back_to_back();
    test_div();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
